// File: rtl/sparse_index_value_joiner.sv
// Joins the decoder's independent index and value streams into (row, col, value) triples.
// Define SPARSE_JOINER_ROW_END_EN to add the row-end lookahead register.

module sparse_index_value_joiner_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SLACK = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data_c,
  output logic         o_empty_c,
  output logic         o_almost_full_c,
  output logic         o_drop_c
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;

  // A push into a full FIFO is refused even when a pop frees a slot that cycle.
  assign w_full          = (r_count == CW'(DEPTH));
  assign w_wr            = i_push && !w_full;
  assign w_rd            = i_pop && !o_empty_c;
  assign o_empty_c       = (r_count == '0);
  assign o_almost_full_c = (r_count >= CW'(DEPTH - SLACK));
  assign o_drop_c        = i_push && w_full;
  assign o_data_c        = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

module sparse_index_value_joiner #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned STALL_SLACK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_nnz,
  input  logic        i_push_index,
  input  logic [31:0] i_row,
  input  logic [31:0] i_col,
  output logic        o_stall_index,
  input  logic        i_push_val,
  input  logic [63:0] i_val,
  output logic        o_stall_val,
  output logic        o_push_out,
  output logic [31:0] o_out_row,
  output logic [31:0] o_out_col,
  output logic [63:0] o_out_val,
  output logic        o_out_row_end,
  input  logic        i_stall_out,
  output logic        o_busy,
  output logic [63:0] o_count,
  output logic        o_overflow
);
  localparam int unsigned RW   = 32;
  localparam int unsigned IW   = 2 * RW;
  localparam int unsigned VW   = 64;
  localparam int unsigned CNTW = 64;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_nnz;
  logic [CNTW-1:0] r_issued;
  logic [CNTW-1:0] r_count;
  logic            r_push_out;
  logic [RW-1:0]   r_out_row;
  logic [RW-1:0]   r_out_col;
  logic [VW-1:0]   r_out_val;
  logic            r_overflow;

  logic [IW-1:0]   w_idx_data;
  logic [RW-1:0]   w_idx_row;
  logic [RW-1:0]   w_idx_col;
  logic [VW-1:0]   w_val_data;
  logic            w_idx_empty;
  logic            w_val_empty;
  logic            w_idx_drop;
  logic            w_val_drop;
  logic            w_pop;
  logic            w_emit;
  logic            w_last;
  logic            w_more;
  logic [RW-1:0]   w_emit_row;
  logic [RW-1:0]   w_emit_col;
  logic [VW-1:0]   w_emit_val;

  sparse_index_value_joiner_fifo #(
    .W(IW), .DEPTH(FIFO_DEPTH), .SLACK(STALL_SLACK)
  ) u_idx_fifo (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_flush         (i_start),
    .i_push          (i_push_index),
    .i_data          ({i_row, i_col}),
    .i_pop           (w_pop),
    .o_data_c        (w_idx_data),
    .o_empty_c       (w_idx_empty),
    .o_almost_full_c (o_stall_index),
    .o_drop_c        (w_idx_drop)
  );

  sparse_index_value_joiner_fifo #(
    .W(VW), .DEPTH(FIFO_DEPTH), .SLACK(STALL_SLACK)
  ) u_val_fifo (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_flush         (i_start),
    .i_push          (i_push_val),
    .i_data          (i_val),
    .i_pop           (w_pop),
    .o_data_c        (w_val_data),
    .o_empty_c       (w_val_empty),
    .o_almost_full_c (o_stall_val),
    .o_drop_c        (w_val_drop)
  );

  assign w_idx_row = w_idx_data[IW-1:RW];
  assign w_idx_col = w_idx_data[RW-1:0];
  assign w_more    = (r_issued < r_nnz);

`ifdef SPARSE_JOINER_ROW_END_EN
  logic            r_hold_valid;
  logic [RW-1:0]   r_hold_row;
  logic [RW-1:0]   r_hold_col;
  logic [VW-1:0]   r_hold_val;
  logic            r_out_row_end;
  logic            w_emit_row_end;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, pop/emit decisions and the triple to register this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    w_emit_row  = w_idx_row;
    w_emit_col  = w_idx_col;
    w_emit_val  = w_val_data;
`ifdef SPARSE_JOINER_ROW_END_EN
    w_emit_row_end = 1'b0;
`endif
    if (i_start) begin
      w_state_nxt = (i_nnz != '0) ? S_RUN : S_IDLE;
    end else if (r_state == S_RUN) begin
`ifdef SPARSE_JOINER_ROW_END_EN
      // The held triple leaves when its successor is popped, or alone once nnz are popped.
      if (!w_idx_empty && !w_val_empty && w_more && !i_stall_out) begin
        w_pop = 1'b1;
        if (r_hold_valid) begin
          w_emit         = 1'b1;
          w_emit_row     = r_hold_row;
          w_emit_col     = r_hold_col;
          w_emit_val     = r_hold_val;
          w_emit_row_end = (r_hold_row != w_idx_row);
        end
      end else if (r_hold_valid && !w_more && !i_stall_out) begin
        w_emit         = 1'b1;
        w_emit_row     = r_hold_row;
        w_emit_col     = r_hold_col;
        w_emit_val     = r_hold_val;
        w_emit_row_end = 1'b1;
      end
`else
      if (!w_idx_empty && !w_val_empty && w_more && !i_stall_out) begin
        w_pop  = 1'b1;
        w_emit = 1'b1;
      end
`endif
      if (w_emit && ((r_count + CNTW'(1)) == r_nnz)) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nnz      <= '0;
      r_issued   <= '0;
      r_count    <= '0;
      r_push_out <= 1'b0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_out_val  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_push_out <= w_emit;
      if (i_start) begin
        r_nnz      <= i_nnz;
        r_issued   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pop)                    r_issued   <= r_issued + CNTW'(1);
        if (w_idx_drop || w_val_drop) r_overflow <= 1'b1;
        if (w_emit) begin
          r_count   <= r_count + CNTW'(1);
          r_out_row <= w_emit_row;
          r_out_col <= w_emit_col;
          r_out_val <= w_emit_val;
        end
      end
    end
  end

`ifdef SPARSE_JOINER_ROW_END_EN
  // Lookahead register; a new start discards whatever it holds.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid  <= 1'b0;
      r_hold_row    <= '0;
      r_hold_col    <= '0;
      r_hold_val    <= '0;
      r_out_row_end <= 1'b0;
    end else begin
      if (i_start) begin
        r_hold_valid <= 1'b0;
      end else if (w_pop) begin
        r_hold_valid <= 1'b1;
        r_hold_row   <= w_idx_row;
        r_hold_col   <= w_idx_col;
        r_hold_val   <= w_val_data;
      end else if (w_emit) begin
        r_hold_valid <= 1'b0;
      end
      if (w_emit && !i_start) r_out_row_end <= w_emit_row_end;
    end
  end

  assign o_out_row_end = r_out_row_end;
`else
  assign o_out_row_end = 1'b0;
`endif

  assign o_push_out = r_push_out;
  assign o_out_row  = r_out_row;
  assign o_out_col  = r_out_col;
  assign o_out_val  = r_out_val;
  assign o_busy     = (r_state == S_RUN);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_sparse_index_value_joiner.sv
// Directed bench for sparse_index_value_joiner with an in-order scoreboard of expected triples.
module tb_sparse_index_value_joiner;
`ifdef SPARSE_JOINER_ROW_END_EN
  localparam bit ROW_END_ON = 1'b1;
`else
  localparam bit ROW_END_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_push_index, i_push_val, i_stall_out;
  logic [63:0] i_nnz, i_val;
  logic [31:0] i_row, i_col;
  logic        o_stall_index, o_stall_val, o_push_out, o_out_row_end, o_busy, o_overflow;
  logic [31:0] o_out_row, o_out_col;
  logic [63:0] o_out_val, o_count;

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic [63:0] val;
    logic        re;
  } trip_t;

  trip_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int cycle = 0;
  int first_out_cyc = -1;
  int last_out_cyc = -1;

  sparse_index_value_joiner dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_nnz(i_nnz),
    .i_push_index(i_push_index), .i_row(i_row), .i_col(i_col), .o_stall_index(o_stall_index),
    .i_push_val(i_push_val), .i_val(i_val), .o_stall_val(o_stall_val),
    .o_push_out(o_push_out), .o_out_row(o_out_row), .o_out_col(o_out_col), .o_out_val(o_out_val),
    .o_out_row_end(o_out_row_end), .i_stall_out(i_stall_out), .o_busy(o_busy),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and score any emitted triple.
  task automatic tick();
    trip_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (o_push_out) begin
      if (q.size() == 0) begin
        check("spurious_push_out", 64'(o_push_out), 64'd0);
      end else begin
        e = q.pop_front();
        check("out_row", 64'(o_out_row), 64'(e.row));
        check("out_col", 64'(o_out_col), 64'(e.col));
        check("out_val", o_out_val, e.val);
        check("out_row_end", 64'(o_out_row_end), 64'(e.re));
        n_out++;
        if (first_out_cyc < 0) first_out_cyc = cycle;
        last_out_cyc = cycle;
      end
    end
  endtask

  task automatic wait_out(input int target, input int budget);
    int k = 0;
    while (n_out < target && k < budget) begin
      tick();
      k++;
    end
    if (n_out < target) check("wait_timeout", 64'(n_out), 64'(target));
  endtask

  task automatic push(input bit pi, input bit pv, input logic [31:0] r, input logic [31:0] c,
                      input logic [63:0] v);
    i_push_index = pi;
    i_push_val   = pv;
    i_row        = r;
    i_col        = c;
    i_val        = v;
    tick();
    i_push_index = 1'b0;
    i_push_val   = 1'b0;
  endtask

  task automatic expect_t(input logic [31:0] r, input logic [31:0] c, input logic [63:0] v,
                          input logic re);
    trip_t e;
    e.row = r; e.col = c; e.val = v; e.re = re;
    q.push_back(e);
  endtask

  task automatic do_start(input logic [63:0] n);
    i_start = 1'b1;
    i_nnz   = n;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    int base;
    int c0;
    int npre;
    i_rst = 1'b1; i_start = 1'b0; i_nnz = '0; i_push_index = 1'b0; i_push_val = 1'b0;
    i_row = '0; i_col = '0; i_val = '0; i_stall_out = 1'b0;
    tick(); tick();
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_count", o_count, 64'd0);
    check("rst_push_out", 64'(o_push_out), 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_stall_index", 64'(o_stall_index), 64'd0);
    check("rst_stall_val", 64'(o_stall_val), 64'd0);
    i_rst = 1'b0;
    tick();

    // Simple join: indices first, values later.
    do_start(64'd3);
    check("simple_busy_rise", 64'(o_busy), 64'd1);
    expect_t(32'd0, 32'd0, 64'h3FF0000000000000, 1'b0);
    expect_t(32'd0, 32'd2, 64'h4000000000000000, ROW_END_ON);
    expect_t(32'd1, 32'd1, 64'h4008000000000000, ROW_END_ON);
    push(1, 0, 32'd0, 32'd0, '0);
    push(1, 0, 32'd0, 32'd2, '0);
    push(1, 0, 32'd1, 32'd1, '0);
    tick();
    first_out_cyc = -1;
    push(0, 1, '0, '0, 64'h3FF0000000000000);
    c0 = cycle;
    push(0, 1, '0, '0, 64'h4000000000000000);
    push(0, 1, '0, '0, 64'h4008000000000000);
    wait_out(3, 20);
    check("simple_count", o_count, 64'd3);
    check("simple_busy_fall", 64'(o_busy), 64'd0);
    check("simple_latency", 64'(first_out_cyc - c0), ROW_END_ON ? 64'd2 : 64'd1);
    tick(); tick(); tick();
    check("simple_no_extra", 64'(n_out), 64'd3);

    // Back-pressure: fill both FIFOs under stall_out, then drain at full rate.
    i_stall_out = 1'b1;
    do_start(64'd16);
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      expect_t(32'(100 + i), 32'(i), v, ROW_END_ON);
      push(1, 1, 32'(100 + i), 32'(i), v);
      if (i == 10) begin
        check("bp_stall_index_11", 64'(o_stall_index), 64'd0);
        check("bp_stall_val_11", 64'(o_stall_val), 64'd0);
      end
      if (i == 11) begin
        check("bp_stall_index_12", 64'(o_stall_index), 64'd1);
        check("bp_stall_val_12", 64'(o_stall_val), 64'd1);
      end
    end
    check("bp_overflow", 64'(o_overflow), 64'd0);
    check("bp_no_output", 64'(n_out), 64'(base));
    i_stall_out = 1'b0;
    first_out_cyc = -1;
    wait_out(base + 16, 40);
    check("bp_back_to_back", 64'(last_out_cyc - first_out_cyc), 64'd15);
    check("bp_count", o_count, 64'd16);
    check("bp_busy", 64'(o_busy), 64'd0);

    // Overflow: 17 index pushes while idle.
    for (int i = 0; i < 17; i++) begin
      push(1, 0, 32'(i), 32'(i), '0);
      if (i == 15) begin
        check("ovf_not_yet", 64'(o_overflow), 64'd0);
        check("ovf_stall_index", 64'(o_stall_index), 64'd1);
      end
      if (i == 16) check("ovf_set", 64'(o_overflow), 64'd1);
    end
    check("ovf_stall_val", 64'(o_stall_val), 64'd0);
    tick(); tick();
    check("ovf_sticky", 64'(o_overflow), 64'd1);

    // Empty matrix with pending entries.
    do_start(64'd0);
    check("empty_ovf_clear", 64'(o_overflow), 64'd0);
    check("empty_stall_flushed", 64'(o_stall_index), 64'd0);
    push(1, 1, 32'd9, 32'd9, 64'd9);
    push(1, 1, 32'd9, 32'd8, 64'd8);
    base = n_out;
    do_start(64'd0);
    check("empty_busy0", 64'(o_busy), 64'd0);
    tick(); tick(); tick(); tick();
    check("empty_busy_stays", 64'(o_busy), 64'd0);
    check("empty_no_output", 64'(n_out), 64'(base));
    check("empty_count", o_count, 64'd0);

    // Abort: restart mid-run after two outputs.
    do_start(64'd10);
    check("abort_busy", 64'(o_busy), 64'd1);
    base = n_out;
    npre = ROW_END_ON ? 3 : 2;
    for (int i = 0; i < npre; i++) begin
      v = {$urandom, $urandom};
      expect_t(32'(200 + i), 32'(i), v, ROW_END_ON);
      push(1, 1, 32'(200 + i), 32'(i), v);
    end
    wait_out(base + 2, 20);
    push(1, 0, 32'd250, 32'd0, '0);
    push(1, 0, 32'd251, 32'd0, '0);
    q.delete();
    do_start(64'd5);
    check("abort_count0", o_count, 64'd0);
    check("abort_busy_restart", 64'(o_busy), 64'd1);
    base = n_out;
    for (int i = 0; i < 5; i++) begin
      v = {$urandom, $urandom};
      expect_t(32'(300 + i), 32'(2 * i), v, ROW_END_ON);
      push(1, 1, 32'(300 + i), 32'(2 * i), v);
    end
    wait_out(base + 5, 20);
    check("abort_count5", o_count, 64'd5);
    check("abort_busy_done", 64'(o_busy), 64'd0);
    tick(); tick(); tick();
    check("abort_exact", 64'(n_out), 64'(base + 5));

    // Reset mid-run with entries buffered.
    do_start(64'd8);
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom};
      expect_t(32'(500 + i), 32'(i), v, ROW_END_ON);
      push(1, 1, 32'(500 + i), 32'(i), v);
    end
    for (int i = 0; i < 3; i++) push(1, 0, 32'(550 + i), 32'd0, '0);
    wait_out(base + (ROW_END_ON ? 2 : 3), 20);
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_count", o_count, 64'd0);
    check("mid_rst_push_out", 64'(o_push_out), 64'd0);
    check("mid_rst_out_row", 64'(o_out_row), 64'd0);
    check("mid_rst_out_val", o_out_val, 64'd0);
    check("mid_rst_row_end", 64'(o_out_row_end), 64'd0);
    q.delete();
    tick();
    i_rst = 1'b0;
    tick();
    do_start(64'd1);
    base = n_out;
    v = {$urandom, $urandom};
    expect_t(32'd400, 32'd7, v, ROW_END_ON);
    push(1, 1, 32'd400, 32'd7, v);
    wait_out(base + 1, 10);
    check("post_rst_count", o_count, 64'd1);
    check("post_rst_busy", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sparse_index_value_joiner.md
# sparse_index_value_joiner

Downstream stage of `sparse_matrix_decoder`: consumes its independent index stream (`push_index`/`row`/`col`) and value stream (`push_val`/`val`), buffers each in a small FIFO, and emits one joined (row, col, value) triple per cycle to the multiply-accumulate stage. It generates back-pressure toward the decoder with `stall_index`/`stall_val` and counts emitted nonzeros against a programmed total. It drops `busy` when the matrix is finished.

## Interface
- `FIFO_DEPTH`, 16: entries per input FIFO; power of two.
- `STALL_SLACK`, 4: a stall is asserted when FIFO occupancy >= `FIFO_DEPTH - STALL_SLACK`.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; loads `nnz`, flushes both FIFOs, clears `count` and `overflow`.
- `nnz`  in  64  total triples to emit; sampled only on `start`.
- `push_index`  in  1  index push from the decoder.
- `row`, `col`  in  32 each  index data.
- `stall_index`  out  1  index FIFO almost full.
- `push_val`  in  1  value push from the decoder.
- `val`  in  64  IEEE double.
- `stall_val`  out  1  value FIFO almost full.
- `push_out`  out  1  one-cycle strobe; a triple is valid.
- `out_row`, `out_col`  out  32 each  joined index.
- `out_val`  out  64  joined value.
- `out_row_end`  out  1  the triple is the last of its row (see Configuration).
- `stall_out`  in  1  downstream stall.
- `busy`  out  1  high from `start` until the final triple is emitted.
- `count`  out  64  triples emitted since `start`.
- `overflow`  out  1  sticky: a push arrived at a full FIFO.

## Operation
- **Reset values.** Every output is 0. FIFOs are empty. The state is IDLE.
- **Writes.** Each FIFO writes on every push when not full. A push to a full FIFO discards its data and sets `overflow`.
- **Stalls are advisory.** The decoder may still push up to `STALL_SLACK` more entries after a stall asserts. `stall_*` are combinational from occupancy.
- **Pushes while IDLE** are buffered. Popping occurs only while `busy`.
- **States.**
  - IDLE: on `start`, go to RUN. If `nnz==0`, `busy` stays 0.
  - RUN: pop both FIFOs together when both are non-empty, `!stall_out`, and `issued < nnz`. `issued` is the number of pops since `start`.
  - RUN -> IDLE: when `count` reaches `nnz`, in the cycle the last `push_out` is registered.
- **Outputs** are registered. `count` increments with each `push_out`; the arithmetic is 64-bit and unsigned, with no wrap in practice.
- **Surplus entries.** Entries beyond `nnz` remain in the FIFOs and are not popped. The next `start` flushes them.
- **`start` while RUN** aborts the current matrix: FIFOs and any held triple are discarded, and RUN restarts with the new `nnz`.
- **Simultaneous push and pop** on the same FIFO: occupancy is unchanged. A push into a full FIFO is not accepted even if a pop occurs in the same cycle.
- **`rst` mid-operation** returns immediately to the reset values.

## Timing
- **Minimum latency.** The later of `push_index`/`push_val` at edge t produces `push_out` high after edge t+1 (row-end feature off) or after t+2 (on, when the next triple is also present).
- **Throughput** is one triple per cycle.
- **`stall_out`** is sampled at the edge. If high, no `push_out` occurs after that edge and the output data holds.
- **`busy`** falls on the same edge that registers the final `push_out`. `start` raises `busy` on the next edge.

## Configuration
- **`SPARSE_JOINER_ROW_END_EN` defined:**
  - One popped triple is held in a lookahead register.
  - The held triple is emitted when the next triple is popped, with `out_row_end = (held row != next row)`.
  - If it is the nnz-th triple, it is emitted one cycle after being popped, with `out_row_end=1`.
  - `stall_out` blocks emission; the register holds.
- **Not defined:** no lookahead register; `out_row_end` is tied to 0.

## Test plan
- **Simple join.** `start`, `nnz=3`; push indices (0,0),(0,2),(1,1) on three consecutive cycles, then values 1.0,2.0,3.0 two cycles later -> three `push_out` in order with matching pairs, `count=3`, `busy` falls with the third triple. With the macro defined, `out_row_end` is 0,1,1.
- **Back-pressure.** Hold `stall_out=1` while pushing 16 indices and values -> `stall_index`/`stall_val` rise at 12 entries, no `push_out`, `overflow=0`. Release -> 16 triples on 16 consecutive cycles.
- **Overflow.** 17 index pushes with no pops -> the 17th is dropped and `overflow=1` until `start`.
- **Empty matrix.** `start` with `nnz=0` and 2 pending entries -> `busy` stays 0, no `push_out`.
- **Abort.** `start` (`nnz=5`) mid-run after 2 outputs -> FIFOs flushed, `count=0`, the new run emits exactly 5 triples.
- **Reset.** Assert `rst` with 3 entries buffered and `busy=1` -> all outputs 0 immediately, FIFOs empty.
